// File: rtl/regchk_pkg.sv
// Shared types and constants for the register-file writeback checker.
package regchk_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_e;

  // ABI indices of the first architectural registers
  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 1;
  localparam int REG_SP   = 2;

  function automatic int rw_of(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regchk_if.sv
// Writeback bus snooped from the core: NPORTS flattened valid/rd/data lanes.
interface regchk_if
  import regchk_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NPORTS = 1
);
  localparam int RW = rw_of(NREGS);

  logic [NPORTS-1:0]      wb_valid;
  logic [NPORTS*RW-1:0]   wb_rd;
  logic [NPORTS*XLEN-1:0] wb_data;

  modport master (output wb_valid, wb_rd, wb_data);
  modport slave  (input  wb_valid, wb_rd, wb_data);

endinterface

// File: rtl/regchk_shadow.sv
// Shadow register file: NPORTS write ports (highest port wins on a shared
// index) and one asynchronous read port; x0 always reads as zero.
module regchk_shadow
  import regchk_pkg::*;
#(
  parameter int  XLEN   = 32,
  parameter int  NREGS  = 32,
  parameter int  NPORTS = 1,
  localparam int RW     = rw_of(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [NPORTS-1:0]      we,
  input  logic [NPORTS*RW-1:0]   wr_idx,
  input  logic [NPORTS*XLEN-1:0] wr_data,
  input  logic [RW-1:0]          rd_idx,
  output logic [XLEN-1:0]        rd_data
);

  logic [XLEN-1:0] regs [NREGS];

  // NOTE: the array is flop-based and reset explicitly because a cleared
  // shadow is architecturally visible on the debug port; a RAM macro could
  // not be cleared in one cycle. Non-blocking assignments let the later
  // (higher-index) port override an earlier one within the same edge.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (we[p] && wr_idx[p*RW +: RW] != RW'(REG_ZERO))
          regs[wr_idx[p*RW +: RW]] <= wr_data[p*XLEN +: XLEN];
      end
    end
  end

  assign rd_data = (rd_idx == RW'(REG_ZERO)) ? '0 : regs[rd_idx];

endmodule

// File: rtl/regfile_checker.sv
// Writeback monitor: shadows register writes during RUN, then sweeps the
// shadow against a preloaded expected table and latches pass/fail details.
module regfile_checker
  import regchk_pkg::*;
#(
  parameter int  XLEN    = 32,
  parameter int  NREGS   = 32,
  parameter int  NPORTS  = 1,
  parameter int  TIMEOUT = 100000,
  localparam int RW      = rw_of(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt,
  regchk_if.slave         wb,
  input  logic            exp_we,
  input  logic [RW-1:0]   exp_idx,
  input  logic [XLEN-1:0] exp_data,
  input  logic            exp_chk,
  input  logic [RW-1:0]   dbg_idx,
  output logic [XLEN-1:0] dbg_data,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [RW:0]     mismatches,
  output logic [RW-1:0]   fail_idx,
  output logic [XLEN-1:0] fail_got,
  output logic [XLEN-1:0] fail_exp,
  output logic [31:0]     wb_count,
  output logic [31:0]     cycle_count
);

  state_e          state, state_n;
  logic [XLEN-1:0] exp_mem [NREGS];
  logic [NREGS-1:0] chk_bits;
  logic [RW-1:0]   chk_idx, rd_idx;
  logic [XLEN-1:0] rd_data;
  logic [NPORTS-1:0] wb_acc;
  logic [31:0]     acc_n;
  logic [32:0]     wb_sum;
  logic            restart, timeout_hit, table_open;

  assign restart     = start && (state == S_IDLE || state == S_DONE);
  assign table_open  = (state == S_IDLE || state == S_DONE);
  assign timeout_hit = (state == S_RUN) && !halt && (cycle_count == 32'(TIMEOUT - 1));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wb_acc = '0;
    acc_n  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      wb_acc[p] = (state == S_RUN) && wb.wb_valid[p] && (wb.wb_rd[p*RW +: RW] != RW'(REG_ZERO));
      if (wb_acc[p]) acc_n = acc_n + 32'd1;
    end
    wb_sum = {1'b0, wb_count} + {1'b0, acc_n};
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (halt || timeout_hit) state_n = S_CHECK;
      S_CHECK: if (chk_idx == RW'(NREGS - 1)) state_n = S_DONE;
      S_DONE:  if (start) state_n = S_RUN;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) exp_mem[i] <= '0;
      chk_bits <= '0;
    end else if (exp_we && table_open) begin
      exp_mem[exp_idx]  <= exp_data;
      chk_bits[exp_idx] <= exp_chk;
    end
  end

  // The single read port serves the check sweep while in CHECK, debug otherwise.
  assign rd_idx   = (state == S_CHECK) ? chk_idx : dbg_idx;
  assign dbg_data = rd_data;

  regchk_shadow #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NPORTS (NPORTS)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .clr     (restart),
    .we      (wb_acc),
    .wr_idx  (wb.wb_rd),
    .wr_data (wb.wb_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      chk_idx     <= RW'(1);
      timeout     <= 1'b0;
      mismatches  <= '0;
      fail_idx    <= '0;
      fail_got    <= '0;
      fail_exp    <= '0;
      wb_count    <= '0;
      cycle_count <= '0;
    end else begin
      if (state == S_RUN) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
        wb_count <= wb_sum[32] ? '1 : wb_sum[31:0];
        if (timeout_hit) timeout <= 1'b1;
      end
      if (state == S_CHECK) begin
        chk_idx <= chk_idx + RW'(1);
        if (chk_bits[chk_idx] && rd_data != exp_mem[chk_idx]) begin
          if (mismatches == '0) begin
            fail_idx <= chk_idx;
            fail_got <= rd_data;
            fail_exp <= exp_mem[chk_idx];
          end
          if (mismatches != '1) mismatches <= mismatches + 1'b1;
        end
      end
    end
  end

  assign busy = (state == S_RUN) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (mismatches == '0) && !timeout;

endmodule

// File: tb/tb_regfile_checker.sv
// Directed plus randomized bench for regfile_checker with a two-port core
// model and a short watchdog; expectations come from an array-based model.
module tb_regfile_checker;
  import regchk_pkg::*;

  localparam int XLEN    = 32;
  localparam int NREGS   = 32;
  localparam int NPORTS  = 2;
  localparam int TIMEOUT = 16;
  localparam int RW      = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0, halt = 1'b0;
  logic            exp_we = 1'b0, exp_chk = 1'b0;
  logic [RW-1:0]   exp_idx = '0, dbg_idx = '0;
  logic [XLEN-1:0] exp_data = '0;
  logic [XLEN-1:0] dbg_data, fail_got, fail_exp;
  logic            busy, done, pass, timeout;
  logic [RW:0]     mismatches;
  logic [RW-1:0]   fail_idx;
  logic [31:0]     wb_count, cycle_count;

  regchk_if #(.XLEN(XLEN), .NREGS(NREGS), .NPORTS(NPORTS)) wbif ();

  regfile_checker #(
    .XLEN(XLEN), .NREGS(NREGS), .NPORTS(NPORTS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .wb(wbif),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data), .exp_chk(exp_chk),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .mismatches(mismatches), .fail_idx(fail_idx),
    .fail_got(fail_got), .fail_exp(fail_exp), .wb_count(wb_count),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Reference model: architectural view of shadow, table and run statistics
  logic [31:0] sh_m [NREGS];
  logic [31:0] ex_m [NREGS];
  bit          ck_m [NREGS];
  int          wbc_m, cyc_m;
  bit          to_m;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_run_model();
    for (int i = 0; i < NREGS; i++) sh_m[i] = '0;
    wbc_m = 0;
    cyc_m = 0;
    to_m  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    clear_run_model();
    for (int i = 0; i < NREGS; i++) begin
      ex_m[i] = '0;
      ck_m[i] = 1'b0;
    end
  endtask

  task automatic load(input int idx, input logic [31:0] data, input bit chk);
    exp_idx = RW'(idx); exp_data = data; exp_chk = chk; exp_we = 1'b1;
    tick();
    exp_we = 1'b0;
    ex_m[idx] = data;
    ck_m[idx] = chk;
  endtask

  task automatic begin_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_run_model();
  endtask

  // One RUN-state cycle with optional writebacks on both ports
  task automatic wb_step(input logic [1:0] v, input int rd0, input logic [31:0] d0,
                         input int rd1, input logic [31:0] d1);
    wbif.wb_valid = v;
    wbif.wb_rd    = {RW'(rd1), RW'(rd0)};
    wbif.wb_data  = {d1, d0};
    tick();
    wbif.wb_valid = '0;
    if (v[0] && rd0 != 0) begin sh_m[rd0] = d0; wbc_m++; end
    if (v[1] && rd1 != 0) begin sh_m[rd1] = d1; wbc_m++; end
    cyc_m++;
    if (cyc_m == TIMEOUT) to_m = 1'b1;
  endtask

  task automatic check_dbg(input string tag, input int idx);
    dbg_idx = RW'(idx);
    #1;
    check(tag, dbg_data, sh_m[idx]);
  endtask

  // Writebacks driven while waiting must be ignored by the checker
  task automatic wait_done();
    int n = 0;
    while (!done && n < 64) begin
      wbif.wb_valid = '1;
      wbif.wb_rd    = {RW'($urandom_range(1, NREGS - 1)), RW'($urandom_range(1, NREGS - 1))};
      wbif.wb_data  = {$urandom, $urandom};
      tick();
      n++;
    end
    wbif.wb_valid = '0;
    check("done_latency", n, NREGS - 1);
  endtask

  task automatic halt_run();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    cyc_m++;
    wait_done();
  endtask

  task automatic check_status(input string tag);
    int mism = 0;
    int fi = 0;
    logic [31:0] fg = '0, fe = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (ck_m[i] && sh_m[i] !== ex_m[i]) begin
        if (mism == 0) begin fi = i; fg = sh_m[i]; fe = ex_m[i]; end
        mism++;
      end
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".pass"}, pass, (mism == 0 && !to_m));
    check({tag, ".mismatches"}, mismatches, mism);
    check({tag, ".fail_idx"}, fail_idx, fi);
    check({tag, ".fail_got"}, fail_got, fg);
    check({tag, ".fail_exp"}, fail_exp, fe);
    check({tag, ".timeout"}, timeout, to_m);
    check({tag, ".wb_count"}, wb_count, wbc_m);
    check({tag, ".cycle_count"}, cycle_count, cyc_m);
    for (int i = 0; i < NREGS; i++) check_dbg({tag, ".dbg"}, i);
  endtask

  // Planned random program for one run
  logic [1:0]  pv  [12];
  int          pr0 [12], pr1 [12];
  logic [31:0] pd0 [12], pd1 [12];
  logic [31:0] fut [NREGS];

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return 32'h7fff_ffff;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    wbif.wb_valid = '0;
    wbif.wb_rd    = '0;
    wbif.wb_data  = '0;

    // Reset state
    do_reset();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pass", pass, 0);
    check("rst.timeout", timeout, 0);
    check("rst.mismatches", mismatches, 0);
    check("rst.wb_count", wb_count, 0);
    check("rst.cycle_count", cycle_count, 0);
    check("rst.fail_got", fail_got, 0);
    check_dbg("rst.dbg", 3);

    // Basic pass, x0 write, two ports to the same register
    load(REG_RA, 32'h7fff_ffff, 1'b1);
    load(REG_SP, 32'h8000_0000, 1'b1);
    begin_run();
    check("run.busy", busy, 1);
    wb_step(2'b01, REG_RA, 32'h7fff_ffff, 0, 0);
    check_dbg("run.dbg_ra", REG_RA);
    wb_step(2'b01, REG_SP, 32'h8000_0000, 0, 0);
    wb_step(2'b01, REG_ZERO, 32'hdead_beef, 0, 0);
    check_dbg("x0.dbg", REG_ZERO);
    check("x0.wb_count", wb_count, wbc_m);
    wb_step(2'b11, 5, 32'h11, 5, 32'h22);
    check_dbg("dual.dbg_x5", 5);
    check("dual.wb_count", wb_count, wbc_m);
    halt_run();
    check_status("basic");

    // Two mismatches; a table write attempted during RUN must not land
    do_reset();
    load(25, 32'h0, 1'b1);
    load(30, 32'h0000_0abc, 1'b1);
    begin_run();
    wb_step(2'b01, 25, 32'h1, 0, 0);
    exp_idx = RW'(3); exp_data = 32'h55; exp_chk = 1'b1; exp_we = 1'b1;
    wb_step(2'b10, 0, 0, 30, 32'h999);
    exp_we = 1'b0;
    halt_run();
    check_status("mism");

    // Watchdog: no halt, all checks would match
    do_reset();
    begin_run();
    for (int k = 0; k < TIMEOUT - 1; k++) wb_step(2'b01, 7, 32'(k), 0, 0);
    check("wdog.pre_timeout", timeout, 0);
    check("wdog.pre_busy", busy, 1);
    wb_step(2'b00, 0, 0, 0, 0);
    check("wdog.timeout", timeout, 1);
    wait_done();
    check_status("wdog");

    // Halt on the same cycle the watchdog would fire: halt wins
    begin_run();
    for (int k = 0; k < TIMEOUT - 1; k++) wb_step(2'b00, 0, 0, 0, 0);
    halt_run();
    check_status("halt_edge");

    // Reset in the middle of CHECK
    load(9, 32'h1, 1'b1);
    begin_run();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    do_reset();
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.mismatches", mismatches, 0);
    begin_run();
    halt_run();
    check_status("midrst");

    // Randomized runs, restarting from DONE with the table rewritten each time
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(3, 12);
      for (int i = 0; i < NREGS; i++) fut[i] = '0;
      for (int k = 0; k < n; k++) begin
        pv[k]  = 2'($urandom);
        pr0[k] = $urandom_range(0, NREGS - 1);
        pr1[k] = ($urandom_range(0, 3) == 0) ? pr0[k] : $urandom_range(0, NREGS - 1);
        pd0[k] = rand_data();
        pd1[k] = rand_data();
        if (pv[k][0] && pr0[k] != 0) fut[pr0[k]] = pd0[k];
        if (pv[k][1] && pr1[k] != 0) fut[pr1[k]] = pd1[k];
      end
      for (int r = 1; r < NREGS; r++)
        load(r, ($urandom_range(0, 5) == 0) ? $urandom : fut[r], $urandom_range(0, 1) == 1);
      begin_run();
      for (int k = 0; k < n; k++) wb_step(pv[k], pr0[k], pd0[k], pr1[k], pd1[k]);
      halt_run();
      check_status("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
